// File: rtl/ex_div_unit_if.sv
// rtl/ex_div_unit_if.sv - EX-stage divider request/result bundle
interface ex_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             div_en;
    logic             div_signed;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             annul;
    logic             stallreq;
    logic             ready;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    logic             div_zero;

    modport master (
        output div_en, div_signed, opa, opb, annul,
        input  stallreq, ready, hi_o, lo_o, div_zero
    );

    modport slave (
        input  div_en, div_signed, opa, opb, annul,
        output stallreq, ready, hi_o, lo_o, div_zero
    );
endinterface

// File: rtl/ex_div_unit.sv
// rtl/ex_div_unit.sv - iterative radix-2 restoring DIV/DIVU unit for the EX stage
// Optional DIV_ZERO_FAST_EN: zero divisor completes in one cycle and flags div_zero.
module ex_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    ex_div_unit_if.slave div
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hip_q, hip_d;
    logic [WIDTH-1:0] lop_q, lop_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;
    logic [WIDTH-1:0] opa_abs;
    logic [WIDTH-1:0] opb_abs;
    logic             ready;

    assign opa_abs = (div.div_signed && div.opa[WIDTH-1]) ? -div.opa : div.opa;
    assign opb_abs = (div.div_signed && div.opb[WIDTH-1]) ? -div.opb : div.opb;

    // Once ge holds the true difference is below 2^WIDTH, so the low bits suffice.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign ge      = shifted >= {1'b0, dvs_q};
    assign diff    = shifted[WIDTH-1:0] - dvs_q;

`ifdef DIV_ZERO_FAST_EN
    logic dz_q, dz_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hip_d   = hip_q;
        lop_d   = lop_q;
`ifdef DIV_ZERO_FAST_EN
        dz_d    = dz_q;
`endif
        case (state_q)
            IDLE: begin
                if (div.div_en && !div.annul) begin
                    rem_d   = '0;
                    quo_d   = opa_abs;
                    dvs_d   = opb_abs;
                    negq_d  = div.div_signed & (div.opa[WIDTH-1] ^ div.opb[WIDTH-1]);
                    negr_d  = div.div_signed & div.opa[WIDTH-1];
                    cnt_d   = '0;
                    state_d = BUSY;
`ifdef DIV_ZERO_FAST_EN
                    dz_d    = 1'b0;
                    if (div.opb == '0) begin
                        state_d = DONE;
                        hip_d   = hi_q;
                        lop_d   = lo_q;
                        hi_d    = div.opa;
                        lo_d    = '0;
                        dz_d    = 1'b1;
                    end
`endif
                end
            end
            BUSY: begin
                if (div.annul) begin
                    state_d = IDLE;
                end else begin
                    rem_d = ge ? diff : shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], ge};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                        hip_d   = hi_q;
                        lop_d   = lo_q;
                        hi_d    = negr_q ? -rem_d : rem_d;
                        lo_d    = negq_q ? -quo_d : quo_d;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                // A flush in the result cycle must leave HI/LO as they were.
                if (div.annul) begin
                    hi_d = hip_q;
                    lo_d = lop_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            hip_q   <= '0;
            lop_q   <= '0;
`ifdef DIV_ZERO_FAST_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hip_q   <= hip_d;
            lop_q   <= lop_d;
`ifdef DIV_ZERO_FAST_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign ready        = (state_q == DONE) && !div.annul;
    assign div.ready    = ready;
    assign div.stallreq = rst & div.div_en & ~ready;
    assign div.hi_o     = hi_q;
    assign div.lo_o     = lo_q;
`ifdef DIV_ZERO_FAST_EN
    assign div.div_zero = ready & dz_q;
`else
    assign div.div_zero = 1'b0;
`endif
endmodule

// File: tb/tb_ex_div_unit.sv
// tb/tb_ex_div_unit.sv - directed self-checking bench for ex_div_unit
module tb_ex_div_unit;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    ex_div_unit_if #(.WIDTH(32)) bus ();

    ex_div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .div (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                           input int exp_lat, input logic exp_dz);
        int   lat;
        int   stalls;
        logic seen;
        bus.div_en     = 1'b1;
        bus.div_signed = sgn;
        bus.opa        = a;
        bus.opb        = b;
        lat    = 0;
        stalls = 0;
        seen   = 1'b0;
        #1;
        while (!seen && lat < 100) begin
            if (bus.ready) begin
                seen = 1'b1;
            end else begin
                if (bus.stallreq) stalls++;
                @(negedge clk);
                #1;
                lat++;
            end
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_stall_cycles"}, stalls, exp_lat);
        chk({tag, "_stall_in_done"}, {31'd0, bus.stallreq}, 32'd0);
        chk({tag, "_lo"}, bus.lo_o, exp_lo);
        chk({tag, "_hi"}, bus.hi_o, exp_hi);
        chk({tag, "_div_zero"}, {31'd0, bus.div_zero}, {31'd0, exp_dz});
        @(negedge clk);
        bus.div_en = 1'b0;
        #1;
        chk({tag, "_ready_pulse"}, {31'd0, bus.ready}, 32'd0);
        chk({tag, "_stall_after"}, {31'd0, bus.stallreq}, 32'd0);
        chk({tag, "_lo_hold"}, bus.lo_o, exp_lo);
        chk({tag, "_dz_after"}, {31'd0, bus.div_zero}, 32'd0);
    endtask

    task automatic watch_quiet(input string tag, input int cycles);
        logic seen_rdy;
        logic seen_stall;
        seen_rdy   = 1'b0;
        seen_stall = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            #1;
            if (bus.ready) seen_rdy = 1'b1;
            if (bus.stallreq) seen_stall = 1'b1;
        end
        chk({tag, "_no_ready"}, {31'd0, seen_rdy}, 32'd0);
        chk({tag, "_no_stall"}, {31'd0, seen_stall}, 32'd0);
    endtask

    initial begin
        logic seen;
        errors         = 0;
        checks         = 0;
        rst            = 1'b0;
        bus.div_en     = 1'b0;
        bus.div_signed = 1'b0;
        bus.opa        = '0;
        bus.opb        = '0;
        bus.annul      = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_ready", {31'd0, bus.ready}, 32'd0);
        chk("reset_stall", {31'd0, bus.stallreq}, 32'd0);
        chk("reset_hi", bus.hi_o, 32'd0);
        chk("reset_lo", bus.lo_o, 32'd0);
        chk("reset_dz", {31'd0, bus.div_zero}, 32'd0);

        run_div("divu_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33, 1'b0);
        run_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 1'b0);
        run_div("divu_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 33, 1'b0);
        run_div("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 33, 1'b0);

        // Annul in BUSY: no result, HI/LO keep the overflow result.
        bus.div_en     = 1'b1;
        bus.div_signed = 1'b0;
        bus.opa        = 32'd1000;
        bus.opb        = 32'd3;
        seen           = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            #1;
            if (bus.ready) seen = 1'b1;
            bus.annul = (i == 10);
        end
        chk("annul_no_ready", {31'd0, seen}, 32'd0);
        chk("annul_lo_hold", bus.lo_o, 32'h8000_0000);
        chk("annul_hi_hold", bus.hi_o, 32'd0);
        run_div("restart_9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 33, 1'b0);

        // Annul together with div_en in IDLE must not start.
        bus.div_en = 1'b1;
        bus.annul  = 1'b1;
        bus.opa    = 32'd50;
        bus.opb    = 32'd5;
        @(negedge clk);
        bus.div_en = 1'b0;
        bus.annul  = 1'b0;
        watch_quiet("idle_annul", 40);
        chk("idle_annul_lo", bus.lo_o, 32'd3);

        // Asynchronous reset in the middle of BUSY.
        bus.div_en = 1'b1;
        bus.opa    = 32'd100;
        bus.opb    = 32'd7;
        repeat (6) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_busy_ready", {31'd0, bus.ready}, 32'd0);
        chk("rst_busy_stall", {31'd0, bus.stallreq}, 32'd0);
        chk("rst_busy_lo", bus.lo_o, 32'd0);
        chk("rst_busy_hi", bus.hi_o, 32'd0);
        chk("rst_busy_dz", {31'd0, bus.div_zero}, 32'd0);
        @(negedge clk);
        bus.div_en = 1'b0;
        rst        = 1'b1;
        watch_quiet("post_rst", 40);

`ifdef DIV_ZERO_FAST_EN
        run_div("divu_5_0", 32'd5, 32'd0, 1'b0, 32'd0, 32'd5, 1, 1'b1);
`else
        run_div("divu_5_0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 33, 1'b0);
`endif
        run_div("divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 33, 1'b0);
        run_div("div_m100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 33, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
